// File: rtl/bit_mask_builder.sv
// Collects bit indices from a stream of beats into a mask, one frame at a time.
// The finished mask, its popcount and a duplicate/out-of-range flag are held until the consumer takes them.
module bit_mask_builder #(
    parameter int unsigned DAT_W = 8,
    localparam int unsigned IDX_W = $clog2(DAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_in,
    output logic             rdy_in,
    input  logic [IDX_W-1:0] idx_in,
    input  logic             last_in,
    output logic             vld_out,
    input  logic             rdy_out,
    output logic [DAT_W-1:0] dat_out,
    output logic [IDX_W:0]   cnt_out,
    output logic             err_out
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DAT_W-1:0] acc_mask;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_err;

    logic [DAT_W-1:0] base_mask;
    logic [CNT_W-1:0] base_cnt;
    logic             base_err;
    logic [DAT_W-1:0] mask_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;

    logic             in_xfer;
    logic             out_xfer;
    logic             in_range;
    logic [DAT_W-1:0] onehot;

    assign in_xfer  = vld_in & rdy_in;
    assign out_xfer = vld_out & rdy_out;
    assign in_range = {1'b0, idx_in} < CNT_W'(DAT_W);
    assign onehot   = in_range ? (DAT_W'(1) << idx_in) : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a last beat closes the frame, also when it arrives alongside a handoff
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (in_xfer && last_in) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    state_nxt = (in_xfer && last_in) ? HOLD : ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Ready never depends on vld_in
    always_comb begin
        rdy_in = 1'b1;
        if (state == HOLD) begin
            rdy_in = rdy_out;
        end
    end

    // Accumulator update; a handoff in HOLD restarts the frame from empty before applying the beat
    always_comb begin
        base_mask = acc_mask;
        base_cnt  = acc_cnt;
        base_err  = acc_err;
        if (state == HOLD && out_xfer) begin
            base_mask = '0;
            base_cnt  = '0;
            base_err  = 1'b0;
        end
        mask_nxt = base_mask;
        cnt_nxt  = base_cnt;
        err_nxt  = base_err;
        if (in_xfer) begin
            if (in_range && ((base_mask & onehot) == '0)) begin
                mask_nxt = base_mask | onehot;
                cnt_nxt  = base_cnt + CNT_W'(1);
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_mask <= '0;
            acc_cnt  <= '0;
            acc_err  <= 1'b0;
            vld_out  <= 1'b0;
            dat_out  <= '0;
            cnt_out  <= '0;
            err_out  <= 1'b0;
        end else begin
            acc_mask <= mask_nxt;
            acc_cnt  <= cnt_nxt;
            acc_err  <= err_nxt;
            vld_out  <= (state_nxt == HOLD);
            // Partial frames stay hidden; only a completed frame reaches the outputs
            if (state_nxt == HOLD) begin
                dat_out <= mask_nxt;
                cnt_out <= cnt_nxt;
                err_out <= err_nxt;
            end else begin
                dat_out <= '0;
                cnt_out <= '0;
                err_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_mask_builder.sv
// Drives an 8-bit and a 6-bit mask builder with identical beats and compares both
// against a frame-level set model.
module tb_bit_mask_builder;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld_in;
    logic       last_in;
    logic       rdy_out;
    logic [2:0] idx_in;

    logic       rdy8, vld8, err8;
    logic [7:0] dat8;
    logic [3:0] cnt8;
    logic       rdy6, vld6, err6;
    logic [5:0] dat6;
    logic [3:0] cnt6;

    int checks   = 0;
    int failures = 0;

    int unsigned width [2] = '{8, 6};
    bit          m_hold[2];
    bit          m_seen[2][8];
    bit          m_perr[2];
    logic [7:0]  m_mask[2];
    int          m_cnt [2];
    bit          m_err [2];

    always #5 clk = ~clk;

    bit_mask_builder #(.DAT_W(8)) dut8 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy8), .idx_in(idx_in),
        .last_in(last_in), .vld_out(vld8), .rdy_out(rdy_out), .dat_out(dat8),
        .cnt_out(cnt8), .err_out(err8)
    );

    bit_mask_builder #(.DAT_W(6)) dut6 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy6), .idx_in(idx_in),
        .last_in(last_in), .vld_out(vld6), .rdy_out(rdy_out), .dat_out(dat6),
        .cnt_out(cnt6), .err_out(err6)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 1'b0;
            m_perr[k] = 1'b0;
            m_mask[k] = '0;
            m_cnt[k]  = 0;
            m_err[k]  = 1'b0;
            for (int i = 0; i < 8; i++) m_seen[k][i] = 1'b0;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":vld8"}, 8'(vld8), 8'(m_hold[0]));
        chk({tag, ":dat8"}, dat8, m_hold[0] ? m_mask[0] : 8'h00);
        chk({tag, ":cnt8"}, 8'(cnt8), m_hold[0] ? 8'(m_cnt[0]) : 8'h00);
        chk({tag, ":err8"}, 8'(err8), m_hold[0] ? 8'(m_err[0]) : 8'h00);
        chk({tag, ":vld6"}, 8'(vld6), 8'(m_hold[1]));
        chk({tag, ":dat6"}, 8'(dat6), m_hold[1] ? m_mask[1] : 8'h00);
        chk({tag, ":cnt6"}, 8'(cnt6), m_hold[1] ? 8'(m_cnt[1]) : 8'h00);
        chk({tag, ":err6"}, 8'(err6), m_hold[1] ? 8'(m_err[1]) : 8'h00);
    endtask

    // One clock: drive beat, check ready, advance model on the edge, check outputs
    task automatic cycle(input bit v, input int idx, input bit last, input bit ro, input string tag);
        bit         exp_rdy[2];
        bit         in_x;
        bit         out_x;
        logic [7:0] mk;
        int         n;
        vld_in  = v;
        idx_in  = 3'(idx);
        last_in = last;
        rdy_out = ro;
        #1;
        for (int k = 0; k < 2; k++) exp_rdy[k] = !m_hold[k] || ro;
        chk({tag, ":rdy8"}, 8'(rdy8), 8'(exp_rdy[0]));
        chk({tag, ":rdy6"}, 8'(rdy6), 8'(exp_rdy[1]));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            in_x  = v && exp_rdy[k];
            out_x = m_hold[k] && ro;
            if (out_x) m_hold[k] = 1'b0;
            if (in_x) begin
                if (idx < int'(width[k]) && !m_seen[k][idx]) m_seen[k][idx] = 1'b1;
                else m_perr[k] = 1'b1;
                if (last) begin
                    mk = '0;
                    n  = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (m_seen[k][i]) begin
                            mk[i] = 1'b1;
                            n++;
                        end
                        m_seen[k][i] = 1'b0;
                    end
                    m_mask[k] = mk;
                    m_cnt[k]  = n;
                    m_err[k]  = m_perr[k];
                    m_perr[k] = 1'b0;
                    m_hold[k] = 1'b1;
                end
            end
        end
        #1;
        check_outs(tag);
    endtask

    // Reset with a live beat and handoff presented, which must be discarded
    task automatic do_reset(input string tag);
        rst     = 1'b1;
        vld_in  = 1'b1;
        idx_in  = 3'd3;
        last_in = 1'b1;
        rdy_out = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check_outs(tag);
    endtask

    initial begin
        rst     = 1'b1;
        vld_in  = 1'b0;
        idx_in  = '0;
        last_in = 1'b0;
        rdy_out = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outs("reset");

        // Three-beat frame taken immediately
        cycle(1, 3, 0, 1, "f3_a");
        cycle(1, 0, 0, 1, "f3_b");
        cycle(1, 7, 1, 1, "f3_c");
        chk("f3_dat_const", dat8, 8'h89);
        cycle(0, 0, 0, 1, "f3_take");

        // Duplicate index
        cycle(1, 2, 0, 1, "dup_a");
        cycle(1, 2, 1, 1, "dup_b");
        chk("dup_err_const", 8'(err8), 8'h01);
        cycle(0, 0, 0, 1, "dup_take");

        // Stalled consumer: mask held, ready low
        cycle(1, 5, 1, 0, "stall_in");
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, "stall_hold");
        cycle(0, 0, 0, 1, "stall_take");
        cycle(1, 4, 1, 1, "stall_next");
        cycle(0, 0, 0, 1, "stall_next_take");

        // Back-to-back single-beat frames
        for (int i = 0; i < 4; i++) cycle(1, i, 1, 1, "b2b");
        cycle(0, 0, 0, 1, "b2b_take");

        // Reset mid-frame discards partial mask
        cycle(1, 1, 0, 1, "mid_a");
        cycle(1, 4, 0, 1, "mid_b");
        do_reset("mid_rst");
        cycle(1, 6, 1, 1, "mid_c");
        chk("mid_dat_const", dat8, 8'h40);
        cycle(0, 0, 0, 1, "mid_take");

        // Index beyond the 6-bit mask
        cycle(1, 7, 1, 1, "oor");
        chk("oor_err6_const", 8'(err6), 8'h01);
        cycle(0, 0, 0, 1, "oor_take");

        // Full mask and reset during HOLD
        for (int i = 0; i < 8; i++) cycle(1, i, i == 7, 0, "full");
        cycle(0, 0, 0, 0, "full_hold");
        do_reset("hold_rst");

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset("rand_rst");
            end else begin
                cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
